// File: rtl/datamem_if.sv
// Memory-stage data bus between the datapath and the data memory.
// master: address/controls/write data out, read data in; slave: the reverse.
interface datamem_if;
    logic [63:0] address;
    logic        write_enable;
    logic        read_enable;
    logic [63:0] write_data;
    logic [3:0]  xfer_size;
    logic [63:0] read_data;

    modport master (
        output address, write_enable, read_enable, write_data, xfer_size,
        input  read_data
    );

    modport slave (
        input  address, write_enable, read_enable, write_data, xfer_size,
        output read_data
    );
endinterface

// File: rtl/datamem.sv
// Byte-addressed big-endian data memory: combinational read, clocked write.
// Ports: clk, rst_n (async, active-low, clears storage), bus (datamem_if.slave).
module datamem #(
    parameter int DATA_MEM_SIZE = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    datamem_if.slave   bus
);
    localparam int AW = $clog2(DATA_MEM_SIZE);

    logic [7:0]    mem [DATA_MEM_SIZE];
    logic [3:0]    n;
    logic [6:0]    sh;
    logic          aligned;
    logic          in_range;
    logic          ok;
    logic [AW-1:0] base;
    logic [63:0]   wd_top;
    logic [63:0]   raw;

    // Sizes other than 1, 2, 4 all mean a full 8-byte transfer.
    always_comb begin
        case (bus.xfer_size)
            4'd1:    n = 4'd1;
            4'd2:    n = 4'd2;
            4'd4:    n = 4'd4;
            default: n = 4'd8;
        endcase
    end

    // Shift that moves an N-byte quantity between the low and high end of 64 bits.
    assign sh       = {4'd8 - n, 3'b000};
    // For N = 8, n[2:0] - 1 wraps to 3'b111, giving the right mask.
    assign aligned  = (bus.address[2:0] & (n[2:0] - 3'd1)) == 3'd0;
    assign in_range = bus.address <= (64'(DATA_MEM_SIZE) - {60'd0, n});
    assign ok       = aligned && in_range;
    assign base     = bus.address[AW-1:0];

    // Transfer bytes moved to the top so byte i of the access is bits [63-8i -: 8].
    assign wd_top   = bus.write_data << sh;

    for (genvar j = 0; j < DATA_MEM_SIZE; j++) begin : g_byte
        logic [7:0] q;
        logic [AW:0] off;

        // Offset of this byte from the access base; wraps large when below base.
        assign off = (AW + 1)'(j) - {1'b0, base};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= 8'h00;
            end else if (bus.write_enable && ok && off < (AW + 1)'(n)) begin
                q <= wd_top[8 * (7 - int'(off[2:0])) +: 8];
            end
        end

        assign mem[j] = q;
    end

    // Gather eight bytes from base upward, then slide the first N down to the LSBs.
    always_comb begin
        raw = '0;
        if (ok) begin
            for (int k = 0; k < 8; k++) begin
                raw[63 - 8 * k -: 8] = mem[base + AW'(k)];
            end
        end
    end

    assign bus.read_data = (bus.read_enable && ok) ? (raw >> sh) : 64'd0;

endmodule

// File: tb/tb_datamem.sv
// Directed self-checking bench for datamem.
// Each scenario task drives vectors and checks hand-computed values inline.
module tb_datamem;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [63:0] rd;

    datamem_if bus ();

    datamem #(.DATA_MEM_SIZE(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [63:0] a, input logic [63:0] d,
                            input logic [3:0] s);
        @(negedge clk);
        bus.address      = a;
        bus.write_data   = d;
        bus.xfer_size    = s;
        bus.write_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a, input logic [3:0] s,
                           output logic [63:0] d);
        bus.address     = a;
        bus.xfer_size   = s;
        bus.read_enable = 1'b1;
        #1;
        d = bus.read_data;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.address      = '0;
        bus.write_data   = '0;
        bus.xfer_size    = 4'd8;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b1;
        #12;
        rst_n = 1'b1;
        #3;
        do_read(64'd0, 4'd8, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL reset_rd0 got=%h exp=%h", rd, 64'd0);
        end
        do_read(64'd8, 4'd8, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL reset_rd8 got=%h exp=%h", rd, 64'd0);
        end
        do_read(64'd1016, 4'd8, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL reset_rd1016 got=%h exp=%h", rd, 64'd0);
        end
    endtask

    task automatic test_round_trip();
        do_write(64'd16, 64'h0123_4567_89AB_CDEF, 4'd8);
        do_read(64'd16, 4'd8, rd);
        checks++;
        if (rd !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL rt_rd8 got=%h exp=%h", rd, 64'h0123_4567_89AB_CDEF);
        end
        do_read(64'd16, 4'd1, rd);
        checks++;
        if (rd !== 64'h01) begin
            errors++;
            $display("FAIL rt_byte16 got=%h exp=%h", rd, 64'h01);
        end
        do_read(64'd23, 4'd1, rd);
        checks++;
        if (rd !== 64'hEF) begin
            errors++;
            $display("FAIL rt_byte23 got=%h exp=%h", rd, 64'hEF);
        end
        do_read(64'd20, 4'd4, rd);
        checks++;
        if (rd !== 64'h89AB_CDEF) begin
            errors++;
            $display("FAIL rt_word20 got=%h exp=%h", rd, 64'h89AB_CDEF);
        end
        do_read(64'd18, 4'd2, rd);
        checks++;
        if (rd !== 64'h4567) begin
            errors++;
            $display("FAIL rt_half18 got=%h exp=%h", rd, 64'h4567);
        end
    endtask

    task automatic test_partial();
        do_write(64'd32, 64'hFFFF_FFFF_FFFF_AABB, 4'd2);
        do_read(64'd32, 4'd8, rd);
        checks++;
        if (rd !== 64'hAABB_0000_0000_0000) begin
            errors++;
            $display("FAIL part_rd8 got=%h exp=%h", rd, 64'hAABB_0000_0000_0000);
        end
        do_read(64'd34, 4'd2, rd);
        checks++;
        if (rd !== 64'h0000) begin
            errors++;
            $display("FAIL part_rd34 got=%h exp=%h", rd, 64'h0);
        end
        do_write(64'd36, 64'hFFFF_FFFF_C0DE_F00D, 4'd4);
        do_read(64'd32, 4'd8, rd);
        checks++;
        if (rd !== 64'hAABB_0000_C0DE_F00D) begin
            errors++;
            $display("FAIL part_word36 got=%h exp=%h", rd, 64'hAABB_0000_C0DE_F00D);
        end
        do_write(64'd33, 64'hFFFF_FFFF_FFFF_FF5A, 4'd1);
        do_read(64'd32, 4'd4, rd);
        checks++;
        if (rd !== 64'hAA5A_0000) begin
            errors++;
            $display("FAIL part_byte33 got=%h exp=%h", rd, 64'hAA5A_0000);
        end
    endtask

    task automatic test_size_enable();
        do_write(64'd40, 64'h1122_3344_5566_7788, 4'd0);
        do_read(64'd40, 4'd8, rd);
        checks++;
        if (rd !== 64'h1122_3344_5566_7788) begin
            errors++;
            $display("FAIL size0_rd got=%h exp=%h", rd, 64'h1122_3344_5566_7788);
        end
        do_read(64'd40, 4'd3, rd);
        checks++;
        if (rd !== 64'h1122_3344_5566_7788) begin
            errors++;
            $display("FAIL size3_rd got=%h exp=%h", rd, 64'h1122_3344_5566_7788);
        end
        bus.read_enable = 1'b0;
        #1;
        checks++;
        if (bus.read_data !== 64'd0) begin
            errors++;
            $display("FAIL ren0 got=%h exp=%h", bus.read_data, 64'd0);
        end
        bus.read_enable = 1'b1;
    endtask

    task automatic test_illegal();
        do_write(64'd3, 64'hDEAD_BEEF, 4'd4);
        do_read(64'd0, 4'd8, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL misalign_wr got=%h exp=%h", rd, 64'd0);
        end
        do_read(64'd18, 4'd4, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL misalign_rd got=%h exp=%h", rd, 64'd0);
        end
        do_write(64'd1020, 64'hCAFE_BABE_1234_5678, 4'd8);
        do_read(64'd1020, 4'd4, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL range_wr got=%h exp=%h", rd, 64'd0);
        end
        do_write(64'h1_0000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 4'd8);
        do_read(64'd0, 4'd8, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL high_addr got=%h exp=%h", rd, 64'd0);
        end
        do_write(64'd1016, 64'h0102_0304_0506_0708, 4'd8);
        do_read(64'd1016, 4'd8, rd);
        checks++;
        if (rd !== 64'h0102_0304_0506_0708) begin
            errors++;
            $display("FAIL top_word got=%h exp=%h", rd, 64'h0102_0304_0506_0708);
        end
        do_read(64'd1024, 4'd1, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL range_rd got=%h exp=%h", rd, 64'd0);
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        bus.address      = 64'd48;
        bus.write_data   = 64'hFEED_FACE_0BAD_F00D;
        bus.xfer_size    = 4'd8;
        bus.write_enable = 1'b1;
        bus.read_enable  = 1'b1;
        #1;
        checks++;
        if (bus.read_data !== 64'd0) begin
            errors++;
            $display("FAIL rdw_old got=%h exp=%h", bus.read_data, 64'd0);
        end
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        checks++;
        if (bus.read_data !== 64'hFEED_FACE_0BAD_F00D) begin
            errors++;
            $display("FAIL rdw_new got=%h exp=%h", bus.read_data, 64'hFEED_FACE_0BAD_F00D);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        do_read(64'd16, 4'd8, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL arst_rd16 got=%h exp=%h", rd, 64'd0);
        end
        do_read(64'd1016, 4'd8, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL arst_rd1016 got=%h exp=%h", rd, 64'd0);
        end
        bus.address      = 64'd16;
        bus.write_data   = 64'h7777_7777_7777_7777;
        bus.write_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_read(64'd16, 4'd8, rd);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL arst_wr_lost got=%h exp=%h", rd, 64'd0);
        end
        do_write(64'd8, 64'h0000_0000_0000_1234, 4'd2);
        do_read(64'd8, 4'd2, rd);
        checks++;
        if (rd !== 64'h1234) begin
            errors++;
            $display("FAIL post_arst_wr got=%h exp=%h", rd, 64'h1234);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_round_trip();
        test_partial();
        test_size_enable();
        test_illegal();
        test_read_during_write();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/datamem.md
Name: datamem

Overview:
- Byte-addressed data memory for the single-cycle CPU datapath; sits in the memory stage and is driven by the ALU result (address), the MemWrite control and register read data.
- Combinational (asynchronous) read; write is committed on the rising clock edge.
- Storage is big-endian: the lowest address holds the most-significant byte of the accessed word.
- Variable transfer size of 1, 2, 4 or 8 bytes.

Parameters:
- DATA_MEM_SIZE, 1024, number of bytes of storage; addresses 0..DATA_MEM_SIZE-1 are valid.

Ports:
- clk  input  1  system clock; writes commit on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address  input  64  byte address of the first byte of the access.
- write_enable  input  1  commit write_data at the next rising clk edge.
- read_enable  input  1  enables the combinational read_data output.
- write_data  input  64  write data; the transfer occupies the low 8*N bits.
- xfer_size  input  4  transfer size N in bytes.
- read_data  output  64  combinational read result.

Behaviour:
- Transfer size decode:
  - xfer_size 1, 2 or 4 gives N = 1, 2 or 4 bytes.
  - Any other value, including 0 and 8, gives N = 8. A 3-bit constant 8 that truncates to 0 therefore still performs 8-byte transfers.
- Reset:
  - While rst_n = 0, all storage bytes are cleared to 8'h00 immediately, independent of clk.
  - Writes are blocked during reset.
  - read_data reflects the cleared contents (0).
- Read path:
  - Purely combinational, zero-cycle latency.
  - If read_enable = 1: read_data[8N-1:0] = {mem[a], mem[a+1], ..., mem[a+N-1]}, with mem[a] as the most-significant byte. read_data[63:8N] = 0 (zero-extended).
  - If read_enable = 0: read_data = 0.
- Write path:
  - Triggered at the rising clk edge when rst_n = 1 and write_enable = 1.
  - mem[a+i] <= write_data[8(N-1-i)+7 -: 8] for i = 0..N-1.
  - write_data[63:8N] is ignored.
- Read-during-write: read shows the old contents until the clock edge, then the new contents (write-first after the edge, no bypass).
- Alignment:
  - An access is aligned when address mod N == 0.
  - A misaligned write does not modify memory.
  - A misaligned read returns 0.
- Range:
  - If address + N > DATA_MEM_SIZE (including any upper address bits set), the write is dropped and the read returns 0.
  - There is no wrap-around.
- Simultaneous read_enable and write_enable is legal. The read returns pre-edge data for that cycle.
- Reset asserted mid-operation: clears memory even if asserted in the same cycle as a pending write; the write is lost.
- No other state; no pipelining; no handshake.

Test Plan:
- Reset then read: rst_n = 0 → 1; read 8 bytes at 0, 8 and 1016 → read_data = 0.
- 8-byte round trip:
  - Write 64'h0123_4567_89AB_CDEF at address 16 with xfer_size 8, one edge.
  - Read address 16 with xfer_size 8 → 64'h0123456789ABCDEF.
  - 1-byte read at 16 → 64'h01; 1-byte read at 23 → 64'hEF.
- Partial writes:
  - Write 64'hFFFF_FFFF_FFFF_AABB at address 32 with xfer_size 2.
  - Read address 32 with xfer_size 8 → 64'hAABB_0000_0000_0000.
  - Read address 34 with xfer_size 2 → 64'h0000.
- Size decode and enable:
  - Write 64'h1122334455667788 at address 40 with xfer_size 0.
  - Read address 40 with xfer_size 8 → 64'h1122334455667788.
  - Same read with read_enable = 0 → 0.
- Illegal accesses:
  - Write at address 3 with xfer_size 4 → memory unchanged, read returns 0.
  - Write at address 1020 with xfer_size 8 → dropped.
  - Write at address 64'h1_0000_0000 → dropped.
- Asynchronous reset: after writes, pulse rst_n low between clock edges → all reads return 0 immediately, before the next clk edge.
